// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared encodings for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// ============================================================================
// Module      : fwd_sel
// Description : Forwarding source select for one ID-stage source operand.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_sel
  import pipe_pkg::*;
#(
  parameter int REG_W = pipe_pkg::REG_W
) (
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  logic             rw_ex,
  input  logic             mr_ex,
  input  logic [REG_W-1:0] rd_ex,
  input  logic             rw_mem,
  input  logic [REG_W-1:0] rd_mem,
  input  logic             rw_wb,
  input  logic [REG_W-1:0] rd_wb,
  output logic [1:0]       sel
);

  logic w_hit_ex;
  logic w_hit_mem;
  logic w_hit_wb;

  // Load data is not yet available in EX, so a load there never forwards.
  assign w_hit_ex  = rw_ex  & ~mr_ex & (rd_ex  != '0) & (rd_ex  == src);
  assign w_hit_mem = rw_mem &          (rd_mem != '0) & (rd_mem == src);
  assign w_hit_wb  = rw_wb  &          (rd_wb  != '0) & (rd_wb  == src);

  always_comb begin
    sel = FWD_RF;
    if (use_src) begin
      if (w_hit_ex) begin
        sel = FWD_EX;
      end else if (w_hit_mem) begin
        sel = FWD_MEM;
      end else if (w_hit_wb) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/kill/bubble sequencing and operand forwarding select for
//               the 5-stage pipeline. Optional macro PERF_CNT_EN adds
//               saturating stall and kill counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W    = pipe_pkg::REG_W,
  parameter int LOAD_LAT = 1
`ifdef PERF_CNT_EN
  ,
  parameter int CNT_W    = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] Rs_D,
  input  logic [REG_W-1:0] Rt_D,
  input  logic             UseRs_D,
  input  logic             UseRt_D,
  input  logic             RegWr_EX,
  input  logic             MemRd_EX,
  input  logic [REG_W-1:0] Rd_EX,
  input  logic             RegWr_MEM,
  input  logic [REG_W-1:0] Rd_MEM,
  input  logic             RegWr_WB,
  input  logic [REG_W-1:0] Rd_WB,
  input  logic             ctrl_xfer_D,
  output logic             disable_PC,
  output logic             disable_IR,
  output logic             kill,
  output logic             bubble_EX,
  output logic [1:0]       FwdA,
  output logic [1:0]       FwdB,
  output logic             busy
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] kill_cnt_o
`endif
);

  localparam logic [2:0] c_cnt_init = 3'(LOAD_LAT - 1);

  hz_state_t  r_state;
  hz_state_t  w_state_nxt;
  logic [2:0] r_stall_cnt;
  logic [2:0] w_stall_cnt_nxt;
  logic       r_kill_pend;
  logic       w_kill_pend_nxt;

  logic       w_lu;
  logic       w_dis;
  logic       w_kill;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_lu = RegWr_EX & MemRd_EX & (Rd_EX != '0) &
                ((UseRs_D & (Rs_D == Rd_EX)) | (UseRt_D & (Rt_D == Rd_EX)));

  fwd_sel #(.REG_W(REG_W)) u_fwd_a (
    .src     (Rs_D),
    .use_src (UseRs_D),
    .rw_ex   (RegWr_EX),
    .mr_ex   (MemRd_EX),
    .rd_ex   (Rd_EX),
    .rw_mem  (RegWr_MEM),
    .rd_mem  (Rd_MEM),
    .rw_wb   (RegWr_WB),
    .rd_wb   (Rd_WB),
    .sel     (w_fwd_a)
  );

  fwd_sel #(.REG_W(REG_W)) u_fwd_b (
    .src     (Rt_D),
    .use_src (UseRt_D),
    .rw_ex   (RegWr_EX),
    .mr_ex   (MemRd_EX),
    .rd_ex   (Rd_EX),
    .rw_mem  (RegWr_MEM),
    .rd_mem  (Rd_MEM),
    .rw_wb   (RegWr_WB),
    .rd_wb   (Rd_WB),
    .sel     (w_fwd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_stall_cnt <= 3'd0;
      r_kill_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_kill_pend <= w_kill_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_stall_cnt_nxt = r_stall_cnt;
    w_kill_pend_nxt = r_kill_pend;
    w_dis           = 1'b0;
    w_kill          = 1'b0;
    case (r_state)
      RUN: begin
        if (w_lu) begin
          w_dis = 1'b1;
          // A transfer resolved behind a stalled load is remembered, not dropped.
          if (ctrl_xfer_D) begin
            w_kill_pend_nxt = 1'b1;
          end
          if (LOAD_LAT > 1) begin
            w_state_nxt     = STALL;
            w_stall_cnt_nxt = c_cnt_init;
          end
        end else begin
          w_kill          = r_kill_pend | ctrl_xfer_D;
          w_kill_pend_nxt = 1'b0;
        end
      end
      STALL: begin
        w_dis           = 1'b1;
        w_stall_cnt_nxt = (r_stall_cnt == 3'd0) ? 3'd0 : r_stall_cnt - 3'd1;
        if (r_stall_cnt <= 3'd1) begin
          w_state_nxt = RUN;
        end
      end
      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  // While reset is held the front end is flushed: IF_ID loads NOP, ID_EX bubbles.
  assign disable_PC = rst_n & w_dis;
  assign disable_IR = rst_n & w_dis;
  assign bubble_EX  = ~rst_n | w_dis;
  assign kill       = ~rst_n | w_kill;
  assign FwdA       = rst_n ? w_fwd_a : FWD_RF;
  assign FwdB       = rst_n ? w_fwd_b : FWD_RF;
  assign busy       = rst_n & (r_state == STALL);

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_perf_stall;
  logic [CNT_W-1:0] r_perf_kill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_kill  <= '0;
    end else begin
      if (disable_PC && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 1'b1;
      end
      if (kill && (r_perf_kill != '1)) begin
        r_perf_kill <= r_perf_kill + 1'b1;
      end
    end
  end

  assign stall_cnt_o = r_perf_stall;
  assign kill_cnt_o  = r_perf_kill;
`endif

  a_kill_vs_hold: assert property (@(posedge clk) disable iff (!rst_n)
    !(kill && disable_IR));
  a_bubble_holds_ir: assert property (@(posedge clk) disable iff (!rst_n)
    (!bubble_EX || disable_IR));

endmodule

`default_nettype wire
